// File: rtl/uart_tx_fifo_ctrl_if.sv
// Signal bundle between the host/transmitter side and the UART transmit FIFO controller.
// The master drives the host and transmitter requests; the slave is the controller.
interface uart_tx_fifo_ctrl_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr;
  logic [7:0]    wdata;
  logic          fifo_en;
  logic          tx_fifo_rst;
  logic          ier_etbei;
  logic          iir_rd_thri;
  logic          pop;
  logic          sreg_empty;
  logic [7:0]    din;
  logic          thre;
  logic          temt;
  logic          thr_irq;
  logic          wr_ovf;
  logic [LW-1:0] level;

  modport master (
    output wr, wdata, fifo_en, tx_fifo_rst, ier_etbei, iir_rd_thri, pop, sreg_empty,
    input  din, thre, temt, thr_irq, wr_ovf, level
  );

  modport slave (
    input  wr, wdata, fifo_en, tx_fifo_rst, ier_etbei, iir_rd_thri, pop, sreg_empty,
    output din, thre, temt, thr_irq, wr_ovf, level
  );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit FIFO: buffers THR writes, hands the head character to the shift engine,
// retires one entry per pop rising edge and produces THRE/TEMT and the THR-empty interrupt.
module uart_tx_fifo_ctrl #(
  parameter int DEPTH = 16
) (
  input logic               clk,
  input logic               rst,
  uart_tx_fifo_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] cap_s;
  logic          pop_q;
  logic          fifo_en_q;
  logic          ier_q;
  logic          thre_q, thre_d;
  logic          thre_prev_q;
  logic          thr_irq_q, thr_irq_d;
  logic          wr_ovf_q, wr_ovf_d;
  logic          pop_rise_s, flush_s, pop_ok_s, full_s, wr_ok_s;
  logic          irq_set_s, irq_clr_s;

  // Next-state computation for pointers, occupancy, overflow and interrupt.
  always_comb begin
    pop_rise_s = bus.pop & ~pop_q;
    flush_s    = bus.tx_fifo_rst | (bus.fifo_en != fifo_en_q);
    cap_s      = bus.fifo_en ? LW'(DEPTH) : LW'(1);
    pop_ok_s   = ~flush_s & pop_rise_s & (level_q != '0);
    // A retire on the same edge frees a slot before the full decision is made.
    full_s     = (level_q == cap_s) & ~pop_ok_s;
    wr_ok_s    = ~flush_s & bus.wr & ~full_s;
    wr_ovf_d   = ~flush_s & bus.wr & full_s;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush_s) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (wr_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (wr_ok_s && !pop_ok_s) begin
        level_d = level_q + LW'(1);
      end else if (!wr_ok_s && pop_ok_s) begin
        level_d = level_q - LW'(1);
      end else begin
        level_d = level_q;
      end
    end
    thre_d = (level_d == '0);

    // Set on a registered-THRE rise, or on enable rise while already empty; clear wins.
    irq_set_s = bus.ier_etbei & thre_q & (~thre_prev_q | ~ier_q);
    irq_clr_s = wr_ok_s | bus.iir_rd_thri | ~bus.ier_etbei;
    if (irq_clr_s) begin
      thr_irq_d = 1'b0;
    end else if (irq_set_s) begin
      thr_irq_d = 1'b1;
    end else begin
      thr_irq_d = thr_irq_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      pop_q       <= 1'b0;
      fifo_en_q   <= 1'b0;
      ier_q       <= 1'b0;
      thre_q      <= 1'b1;
      thre_prev_q <= 1'b1;
      thr_irq_q   <= 1'b0;
      wr_ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      pop_q       <= bus.pop;
      fifo_en_q   <= bus.fifo_en;
      ier_q       <= bus.ier_etbei;
      thre_q      <= thre_d;
      thre_prev_q <= thre_q;
      thr_irq_q   <= thr_irq_d;
      wr_ovf_q    <= wr_ovf_d;
    end
  end

  // Character storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= bus.wdata;
    end
  end

  assign bus.din     = (level_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.thre    = thre_q;
  assign bus.temt    = thre_q & bus.sreg_empty;
  assign bus.thr_irq = thr_irq_q;
  assign bus.wr_ovf  = wr_ovf_q;
  assign bus.level   = level_q;
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Self-checking bench for uart_tx_fifo_ctrl against a queue-based reference model.
module tb_uart_tx_fifo_ctrl;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  uart_tx_fifo_ctrl_if #(.DEPTH(DEPTH)) bus ();
  uart_tx_fifo_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model state: the FIFO contents as a queue plus registered flags.
  logic [7:0] mq[$];
  bit m_pop_prev, m_fen_prev, m_thre, m_thre_prev, m_ier_prev, m_irq, m_ovf;

  task automatic model_reset();
    mq.delete();
    m_pop_prev = 1'b0; m_fen_prev = 1'b0; m_thre = 1'b1; m_thre_prev = 1'b1;
    m_ier_prev = 1'b0; m_irq = 1'b0; m_ovf = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs, then step the clock.
  task automatic tick();
    bit prise, flush, accw, accp, fullc, ovf_n, irq_n, setc, clrc;
    int cap;
    prise = bus.pop && !m_pop_prev;
    flush = bus.tx_fifo_rst || (bus.fifo_en != m_fen_prev);
    cap   = bus.fifo_en ? DEPTH : 1;
    accw = 1'b0; accp = 1'b0; ovf_n = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      accp  = prise && (mq.size() != 0);
      fullc = (mq.size() == cap) && !accp;
      if (bus.wr && fullc) ovf_n = 1'b1;
      else if (bus.wr) accw = 1'b1;
      if (accp) void'(mq.pop_front());
      if (accw) mq.push_back(bus.wdata);
    end
    setc = (bus.ier_etbei && m_thre && !m_thre_prev) || (bus.ier_etbei && !m_ier_prev && m_thre);
    clrc = accw || bus.iir_rd_thri || !bus.ier_etbei;
    irq_n = clrc ? 1'b0 : (setc ? 1'b1 : m_irq);
    m_thre_prev = m_thre;
    m_thre      = (mq.size() == 0);
    m_ier_prev  = bus.ier_etbei;
    m_pop_prev  = bus.pop;
    m_fen_prev  = bus.fifo_en;
    m_irq       = irq_n;
    m_ovf       = ovf_n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d);
    bus.wr = 1'b1; bus.wdata = d;
    tick();
    bus.wr = 1'b0;
  endtask

  task automatic pop_pulse(input int hold);
    bus.pop = 1'b1;
    repeat (hold) tick();
    bus.pop = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.wr = 1'b0; bus.wdata = 8'h00; bus.fifo_en = 1'b1; bus.tx_fifo_rst = 1'b0;
    bus.ier_etbei = 1'b0; bus.iir_rd_thri = 1'b0; bus.pop = 1'b0; bus.sreg_empty = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk_cnt++; if (bus.thre !== 1'b1) $display("FAIL reset_thre got=%b exp=1", bus.thre); else pass_cnt++;
    chk_cnt++; if (bus.level !== LW'(0)) $display("FAIL reset_level got=%0d exp=0", bus.level); else pass_cnt++;
    chk_cnt++; if (bus.din !== 8'h00) $display("FAIL reset_din got=%h exp=00", bus.din); else pass_cnt++;
    chk_cnt++; if (bus.thr_irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", bus.thr_irq); else pass_cnt++;
    chk_cnt++; if (bus.wr_ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus.wr_ovf); else pass_cnt++;
    chk_cnt++; if (bus.temt !== 1'b0) $display("FAIL reset_temt_busy got=%b exp=0", bus.temt); else pass_cnt++;
    rst = 1'b0; bus.sreg_empty = 1'b1;
    #1;
    chk_cnt++; if (bus.temt !== 1'b1) $display("FAIL reset_temt got=%b exp=1", bus.temt); else pass_cnt++;
    tick(); tick();
  endtask

  task automatic test_order();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'hB2; exp_seq[1] = 8'hC3; exp_seq[2] = 8'h00;
    do_write(8'hA1); do_write(8'hB2); do_write(8'hC3);
    chk_cnt++; if (bus.level !== LW'(3)) $display("FAIL order_level got=%0d exp=3", bus.level); else pass_cnt++;
    chk_cnt++; if (bus.din !== 8'hA1) $display("FAIL order_head got=%h exp=a1", bus.din); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      pop_pulse(20);
      chk_cnt++;
      if (bus.din !== exp_seq[i]) $display("FAIL order_din%0d got=%h exp=%h", i, bus.din, exp_seq[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (bus.thre !== 1'b1) $display("FAIL order_thre got=%b exp=1", bus.thre); else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    logic [7:0] exp_d;
    for (int i = 0; i < DEPTH; i++) do_write(8'($urandom_range(0, 254)));
    bus.wr = 1'b1; bus.wdata = 8'hFF;
    tick();
    bus.wr = 1'b0;
    chk_cnt++; if (bus.wr_ovf !== 1'b1) $display("FAIL full_ovf got=%b exp=1", bus.wr_ovf); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.wr_ovf !== 1'b0) $display("FAIL full_ovf_pulse got=%b exp=0", bus.wr_ovf); else pass_cnt++;
    chk_cnt++; if (bus.level !== LW'(DEPTH)) $display("FAIL full_level got=%0d exp=%0d", bus.level, DEPTH); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      exp_d = mq[0];
      chk_cnt++;
      if (bus.din !== exp_d) $display("FAIL wrap_data%0d got=%h exp=%h", i, bus.din, exp_d);
      else pass_cnt++;
      pop_pulse(2);
      do_write(8'($urandom));
    end
    chk_cnt++; if (bus.level !== LW'(DEPTH)) $display("FAIL wrap_level got=%0d exp=%0d", bus.level, DEPTH); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_d;
    bus.wr = 1'b1; bus.wdata = 8'($urandom); bus.pop = 1'b1;
    tick();
    bus.wr = 1'b0;
    exp_d = mq[0];
    chk_cnt++; if (bus.level !== LW'(DEPTH)) $display("FAIL simul_level got=%0d exp=%0d", bus.level, DEPTH); else pass_cnt++;
    chk_cnt++; if (bus.wr_ovf !== 1'b0) $display("FAIL simul_ovf got=%b exp=0", bus.wr_ovf); else pass_cnt++;
    chk_cnt++; if (bus.din !== exp_d) $display("FAIL simul_head got=%h exp=%h", bus.din, exp_d); else pass_cnt++;
    bus.pop = 1'b0;
    tick();
  endtask

  task automatic test_single_entry();
    bus.fifo_en = 1'b0;
    tick();
    chk_cnt++; if (bus.level !== LW'(0)) $display("FAIL single_flush got=%0d exp=0", bus.level); else pass_cnt++;
    do_write(8'h11);
    bus.wr = 1'b1; bus.wdata = 8'h22;
    tick();
    bus.wr = 1'b0;
    chk_cnt++; if (bus.wr_ovf !== 1'b1) $display("FAIL single_ovf got=%b exp=1", bus.wr_ovf); else pass_cnt++;
    chk_cnt++; if (bus.level !== LW'(1)) $display("FAIL single_level got=%0d exp=1", bus.level); else pass_cnt++;
    chk_cnt++; if (bus.din !== 8'h11) $display("FAIL single_head got=%h exp=11", bus.din); else pass_cnt++;
    bus.fifo_en = 1'b1;
    tick();
    chk_cnt++; if (bus.level !== LW'(0)) $display("FAIL single_toggle got=%0d exp=0", bus.level); else pass_cnt++;
  endtask

  task automatic test_irq();
    bus.ier_etbei = 1'b1;
    tick();
    do_write(8'h5A);
    chk_cnt++; if (bus.thr_irq !== 1'b0) $display("FAIL irq_wr_clear got=%b exp=0", bus.thr_irq); else pass_cnt++;
    bus.pop = 1'b1;
    tick();
    chk_cnt++; if (bus.thre !== 1'b1) $display("FAIL irq_thre got=%b exp=1", bus.thre); else pass_cnt++;
    chk_cnt++; if (bus.thr_irq !== 1'b0) $display("FAIL irq_early got=%b exp=0", bus.thr_irq); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.thr_irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", bus.thr_irq); else pass_cnt++;
    bus.pop = 1'b0; bus.iir_rd_thri = 1'b1;
    tick();
    bus.iir_rd_thri = 1'b0;
    chk_cnt++; if (bus.thr_irq !== 1'b0) $display("FAIL irq_iir_clear got=%b exp=0", bus.thr_irq); else pass_cnt++;
    bus.ier_etbei = 1'b0;
    tick();
    bus.ier_etbei = 1'b1;
    tick();
    chk_cnt++; if (bus.thr_irq !== 1'b1) $display("FAIL irq_ier_rise got=%b exp=1", bus.thr_irq); else pass_cnt++;
    do_write(8'h77);
    chk_cnt++; if (bus.thr_irq !== 1'b0) $display("FAIL irq_wr_clear2 got=%b exp=0", bus.thr_irq); else pass_cnt++;
    pop_pulse(2);
    chk_cnt++; if (bus.thr_irq !== m_irq) $display("FAIL irq_model got=%b exp=%b", bus.thr_irq, m_irq); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_write(8'h31); do_write(8'h32); do_write(8'h33);
    bus.pop = 1'b1;
    rst = 1'b1;
    #1;
    chk_cnt++; if (bus.level !== LW'(0)) $display("FAIL midrst_level got=%0d exp=0", bus.level); else pass_cnt++;
    chk_cnt++; if (bus.din !== 8'h00) $display("FAIL midrst_din got=%h exp=00", bus.din); else pass_cnt++;
    chk_cnt++; if (bus.thre !== 1'b1) $display("FAIL midrst_thre got=%b exp=1", bus.thre); else pass_cnt++;
    @(posedge clk);
    #1;
    bus.pop = 1'b0; bus.ier_etbei = 1'b0;
    rst = 1'b0;
    model_reset();
    tick(); tick();
  endtask

  task automatic test_random();
    logic [7:0]    exp_din;
    logic [LW-1:0] exp_lvl;
    for (int c = 0; c < 600; c++) begin
      bus.wr          = ($urandom_range(0, 99) < 55);
      bus.wdata       = 8'($urandom);
      bus.pop         = ($urandom_range(0, 2) != 0);
      bus.tx_fifo_rst = ($urandom_range(0, 79) == 0);
      bus.iir_rd_thri = ($urandom_range(0, 15) == 0);
      bus.sreg_empty  = 1'($urandom);
      if ($urandom_range(0, 99) == 0) bus.fifo_en = ~bus.fifo_en;
      if ($urandom_range(0, 29) == 0) bus.ier_etbei = ~bus.ier_etbei;
      tick();
      exp_din = (mq.size() != 0) ? mq[0] : 8'h00;
      exp_lvl = LW'(mq.size());
      chk_cnt++; if (bus.din !== exp_din) $display("FAIL rnd_din c=%0d got=%h exp=%h", c, bus.din, exp_din); else pass_cnt++;
      chk_cnt++; if (bus.level !== exp_lvl) $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, bus.level, exp_lvl); else pass_cnt++;
      chk_cnt++; if (bus.thre !== m_thre) $display("FAIL rnd_thre c=%0d got=%b exp=%b", c, bus.thre, m_thre); else pass_cnt++;
      chk_cnt++; if (bus.temt !== (m_thre & bus.sreg_empty)) $display("FAIL rnd_temt c=%0d got=%b exp=%b", c, bus.temt, m_thre & bus.sreg_empty); else pass_cnt++;
      chk_cnt++; if (bus.thr_irq !== m_irq) $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, bus.thr_irq, m_irq); else pass_cnt++;
      chk_cnt++; if (bus.wr_ovf !== m_ovf) $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, bus.wr_ovf, m_ovf); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full_wrap();
    test_simultaneous();
    test_single_entry();
    test_irq();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_ctrl.md
# uart_tx_fifo_ctrl

Transmit-side FIFO and status controller that sequences the UART transmitter. It sits between the host register interface (THR writes, FCR/IER control) and the transmit shift engine. It buffers up to DEPTH characters and presents the head character plus an empty flag to the transmitter. It retires one entry per transmitter load and generates the LSR THRE/TEMT status bits and the THR-empty interrupt.

## Interface
- DEPTH, 16, FIFO depth in characters; power of 2, at least 2
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wr  in  1  host write strobe to THR, one character per high cycle
- wdata  in  8  character to enqueue
- fifo_en  in  1  FCR[0]; 1 gives DEPTH-entry mode, 0 gives single-entry (16450) mode
- tx_fifo_rst  in  1  FCR[2] pulse; clears the FIFO
- ier_etbei  in  1  THR-empty interrupt enable
- iir_rd_thri  in  1  pulse; host read IIR while the THRI source is reported, clears the interrupt
- pop  in  1  transmitter load request; level, held high for many cycles
- sreg_empty  in  1  transmitter shift register empty
- din  out  8  head character to the transmitter
- thre  out  1  1 when the FIFO is empty; wired to the transmitter and to LSR[5]
- temt  out  1  LSR[6]; thre AND sreg_empty (combinational)
- thr_irq  out  1  THR-empty interrupt request
- wr_ovf  out  1  one-cycle pulse: a write was dropped because the FIFO was full
- level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is a circular buffer of DEPTH×8 entries with registered rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a registered level count.
- Effective capacity is DEPTH when fifo_en=1 and 1 when fifo_en=0. full means level equals the effective capacity.
- din = mem[rd_ptr] when level!=0, else 8'h00. It is combinational and stable until the entry is retired.
- The pop edge detector registers pop_q. pop_rise = pop & ~pop_q. Only pop_rise retires an entry; a held pop retires exactly one.
- Per-cycle update, highest priority first:
  1. tx_fifo_rst=1, or fifo_en differs from its registered copy: pointers and level are set to 0. A wr or pop_rise in the same cycle is ignored, and wr_ovf stays 0.
  2. wr and not full: write to mem[wr_ptr], then wr_ptr+1.
  3. wr and full: the data is discarded and wr_ovf=1 for one cycle. If pop_rise occurs in the same cycle, the FIFO is not full for this decision and the write is accepted.
  4. pop_rise and level!=0: rd_ptr+1. pop_rise with level==0 is ignored.
  5. level changes by (+1 on accepted write) and (−1 on accepted pop); a simultaneous write and pop leaves level unchanged.
- thre is a register: it is 1 exactly when level is 0 after the update.
- thr_irq is set when:
  - thre rises 0→1 and ier_etbei=1, or
  - ier_etbei rises 0→1 while thre=1.
- thr_irq is cleared by an accepted wr, by iir_rd_thri, or by ier_etbei=0. If a clear and a set occur in the same cycle, the clear wins.

## Timing
- Reset values: pointers 0, level 0, thre 1, thr_irq 0, wr_ovf 0, pop_q 0, din 8'h00. temt follows sreg_empty. Memory contents are not reset.
- Write accepted at edge N: level and thre update after edge N, and din shows the new head in the cycle after N.
- The transmitter samples din on the same edge it raises pop. The controller retires the entry on the following edge, where it sees pop=1 and pop_q=0. din must not change between those two edges, and it does not.
- A retire at edge M makes thre=1 after edge M if the FIFO was at level 1. thr_irq is set after edge M+1 (edge-detect on the registered thre).
- Throughput: one write per cycle; one retire per pop rising edge.
- Reset mid-transfer clears all state immediately. Pending pop edges are lost.

## Test plan
- Reset: rst high for 3 cycles → thre=1, level=0, din=8'h00, thr_irq=0. After release with sreg_empty=1 → temt=1.
- Order: write 8'hA1, 8'hB2, 8'hC3 with fifo_en=1 → level=3 and din=8'hA1. Three pop pulses, each held 20 cycles → din steps to B2, then C3, then 00, and thre=1 after the third retire.
- Full and wrap: 16 writes, then a 17th of 8'hFF → wr_ovf pulses once and level=16. Then alternate pop/write for 40 entries → data is read back in order across the pointer wrap.
- Simultaneous events: FIFO full, wr and pop_rise on the same edge → write accepted, level stays 16, wr_ovf=0.
- Single-entry mode: fifo_en=0, write 8'h11 then 8'h22 → second write dropped with wr_ovf=1. Toggling fifo_en → level=0.
- Interrupt: ier_etbei=1, one character written then retired → thr_irq=1 one cycle after thre rises. iir_rd_thri → thr_irq=0. A new wr also clears it.
